// File: rtl/led7seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining LED7SEG_LZB_EN.
module led7seg_scan_ctrl #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  output logic        ready,
  output logic        o3,
  output logic        o2,
  output logic        o1,
  output logic        o0,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  // Handshake: a load is taken on any clock edge where load && ready are both
  // high; ready drops on the following cycle and rises again once the shadow
  // value has been moved into the display at a frame boundary.

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   disp, disp_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic          pending, pending_nxt;
  logic          ready_nxt;
  logic [0:0]    state, state_nxt;
  logic          slot_end;
  logic          frame_end;
  logic          accept;
  logic [3:0]    nib_nxt;
  logic [3:0]    lit;
  logic [3:0]    an_nxt;
  logic          frame_tick_nxt;

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == 2'd3);
    accept    = load && ready;

    cnt_nxt = slot_end ? '0 : cnt + CW'(1);
    idx_nxt = slot_end ? idx + 2'd1 : idx;

    disp_nxt    = disp;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    ready_nxt   = ready;
    // A load accepted on the boundary cycle itself lands in the shadow only,
    // so it is carried to the following boundary.
    if (frame_end && pending) begin
      disp_nxt    = shadow;
      pending_nxt = 1'b0;
      ready_nxt   = 1'b1;
    end
    if (accept) begin
      shadow_nxt  = data;
      pending_nxt = 1'b1;
      ready_nxt   = 1'b0;
    end

    state_nxt = (cnt_nxt < BLANK_LIM) ? ST_BLANK : ST_SHOW;
  end

  always_comb begin
    nib_nxt = 4'h0;
    case (idx_nxt)
      2'd0:    nib_nxt = disp_nxt[3:0];
      2'd1:    nib_nxt = disp_nxt[7:4];
      2'd2:    nib_nxt = disp_nxt[11:8];
      default: nib_nxt = disp_nxt[15:12];
    endcase
  end

`ifdef LED7SEG_LZB_EN
  // A digit stays dark only while it and every digit to its left are zero.
  always_comb begin
    lit    = 4'h0;
    lit[3] = (disp_nxt[15:12] != 4'h0);
    lit[2] = lit[3] || (disp_nxt[11:8] != 4'h0);
    lit[1] = lit[2] || (disp_nxt[7:4] != 4'h0);
    lit[0] = 1'b1;
  end
`else
  assign lit = 4'hF;
`endif

  always_comb begin
    an_nxt = 4'hF;
    if (state_nxt == ST_SHOW && lit[idx_nxt])
      an_nxt = ~(4'b0001 << idx_nxt);
    frame_tick_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == 2'd3);
  end

  // Outputs are registered from next-state values so they line up with cnt/idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      disp       <= 16'h0000;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      ready      <= 1'b1;
      state      <= ST_BLANK;
      an         <= 4'hF;
      o3         <= 1'b0;
      o2         <= 1'b0;
      o1         <= 1'b0;
      o0         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      disp       <= disp_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      ready      <= ready_nxt;
      state      <= state_nxt;
      an         <= an_nxt;
      o3         <= nib_nxt[3];
      o2         <= nib_nxt[2];
      o1         <= nib_nxt[1];
      o0         <= nib_nxt[0];
      frame_tick <= frame_tick_nxt;
    end
  end

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// Directed bench for led7seg_scan_ctrl at PRESCALE=8, BLANK_CYC=2.
// Expectations follow LED7SEG_LZB_EN when that macro is defined for the build.
module tb_led7seg_scan_ctrl;

  localparam int PRESCALE  = 8;
  localparam int BLANK_CYC = 2;

`ifdef LED7SEG_LZB_EN
  localparam logic [3:0] ZERO_MASK = 4'b0001;
  localparam logic [3:0] M0070     = 4'b0011;
`else
  localparam logic [3:0] ZERO_MASK = 4'b1111;
  localparam logic [3:0] M0070     = 4'b1111;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        ready;
  logic        o3, o2, o1, o0;
  logic [3:0]  an;
  logic        frame_tick;
  logic [3:0]  o_bus;

  int t;
  int vecs;
  int errs;

  assign o_bus = {o3, o2, o1, o0};

  led7seg_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .ready      (ready),
    .o3         (o3),
    .o2         (o2),
    .o1         (o1),
    .o0         (o0),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    step();
    step();
    rst = 1'b0;
    t   = 0;
  endtask

  // t counts edges since reset release: cnt = t%8, idx = (t/8)%4.
  function automatic logic [3:0] exp_an(int tt, logic [3:0] mask);
    int c;
    int k;
    c = tt % PRESCALE;
    k = (tt / PRESCALE) % 4;
    if (c < BLANK_CYC || !mask[k]) return 4'hF;
    return ~(4'b0001 << k);
  endfunction

  function automatic logic [3:0] exp_nib(int tt, logic [15:0] v);
    int k;
    k = (tt / PRESCALE) % 4;
    return v[k*4 +: 4];
  endfunction

  function automatic logic exp_ft(int tt);
    return (tt % (4 * PRESCALE)) == (4 * PRESCALE - 1);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    load = 1'b1; data = 16'h8888;
    step();
    load = 1'b0;
    while (t < 35) step();
    load = 1'b1; data = 16'h1111;
    step();
    load = 1'b0;
    while (t < 43) step();
    if (an !== 4'b1101) begin $display("FAIL reset_pre_an got %b want %b", an, 4'b1101); errs++; end
    vecs++;
    if (o_bus !== 4'h8) begin $display("FAIL reset_pre_o got %h want %h", o_bus, 4'h8); errs++; end
    vecs++;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (an !== 4'hF) begin $display("FAIL reset_an cyc=%0d got %b want 1111", i, an); errs++; end
      vecs++;
      if (o_bus !== 4'h0) begin $display("FAIL reset_o cyc=%0d got %h want 0", i, o_bus); errs++; end
      vecs++;
      if (ready !== 1'b1) begin $display("FAIL reset_ready cyc=%0d got %b want 1", i, ready); errs++; end
      vecs++;
      if (frame_tick !== 1'b0) begin $display("FAIL reset_ft cyc=%0d got %b want 0", i, frame_tick); errs++; end
      vecs++;
    end
    rst = 1'b0;
    t = 0;
    if (an !== 4'hF) begin $display("FAIL reset_rel0_an got %b want 1111", an); errs++; end
    vecs++;
    step();
    if (an !== 4'hF) begin $display("FAIL reset_rel1_an got %b want 1111", an); errs++; end
    vecs++;
    step();
    if (an !== 4'b1110) begin $display("FAIL reset_rel2_an got %b want 1110", an); errs++; end
    vecs++;
    if (o_bus !== 4'h0) begin $display("FAIL reset_rel2_o got %h want 0", o_bus); errs++; end
    vecs++;
  endtask

  task automatic test_scan();
    do_reset();
    while (t <= 70) begin
      if (an !== exp_an(t, ZERO_MASK)) begin
        $display("FAIL scan_an t=%0d got %b want %b", t, an, exp_an(t, ZERO_MASK)); errs++;
      end
      vecs++;
      if (frame_tick !== exp_ft(t)) begin
        $display("FAIL scan_ft t=%0d got %b want %b", t, frame_tick, exp_ft(t)); errs++;
      end
      vecs++;
      if (o_bus !== 4'h0) begin $display("FAIL scan_o t=%0d got %h want 0", t, o_bus); errs++; end
      vecs++;
      if (ready !== 1'b1) begin $display("FAIL scan_ready t=%0d got %b want 1", t, ready); errs++; end
      vecs++;
      step();
    end
  endtask

  task automatic test_load();
    do_reset();
    while (t < 10) step();
    load = 1'b1; data = 16'h1234;
    step();
    load = 1'b0;
    while (t < 32) begin
      if (ready !== 1'b0) begin $display("FAIL load_ready_lo t=%0d got %b want 0", t, ready); errs++; end
      vecs++;
      if (o_bus !== 4'h0) begin $display("FAIL load_o_old t=%0d got %h want 0", t, o_bus); errs++; end
      vecs++;
      if (an !== exp_an(t, ZERO_MASK)) begin
        $display("FAIL load_an_old t=%0d got %b want %b", t, an, exp_an(t, ZERO_MASK)); errs++;
      end
      vecs++;
      if (frame_tick !== exp_ft(t)) begin
        $display("FAIL load_ft t=%0d got %b want %b", t, frame_tick, exp_ft(t)); errs++;
      end
      vecs++;
      step();
    end
    while (t < 64) begin
      if (ready !== 1'b1) begin $display("FAIL load_ready_hi t=%0d got %b want 1", t, ready); errs++; end
      vecs++;
      if (o_bus !== exp_nib(t, 16'h1234)) begin
        $display("FAIL load_o_new t=%0d got %h want %h", t, o_bus, exp_nib(t, 16'h1234)); errs++;
      end
      vecs++;
      if (an !== exp_an(t, 4'hF)) begin
        $display("FAIL load_an_new t=%0d got %b want %b", t, an, exp_an(t, 4'hF)); errs++;
      end
      vecs++;
      step();
    end
  endtask

  task automatic test_rejected_load();
    do_reset();
    while (t < 5) step();
    load = 1'b1; data = 16'h1234;
    step();
    data = 16'h9999;
    while (t < 13) step();
    load = 1'b0;
    while (t < 32) begin
      if (ready !== 1'b0) begin $display("FAIL rej_ready_lo t=%0d got %b want 0", t, ready); errs++; end
      vecs++;
      if (o_bus !== 4'h0) begin $display("FAIL rej_o_old t=%0d got %h want 0", t, o_bus); errs++; end
      vecs++;
      step();
    end
    while (t < 64) begin
      if (o_bus !== exp_nib(t, 16'h1234)) begin
        $display("FAIL rej_o_new t=%0d got %h want %h", t, o_bus, exp_nib(t, 16'h1234)); errs++;
      end
      vecs++;
      if (ready !== 1'b1) begin $display("FAIL rej_ready_hi t=%0d got %b want 1", t, ready); errs++; end
      vecs++;
      step();
    end
  endtask

  task automatic test_boundary_load();
    do_reset();
    while (t < 31) step();
    if (frame_tick !== 1'b1) begin $display("FAIL bnd_ft t=%0d got %b want 1", t, frame_tick); errs++; end
    vecs++;
    load = 1'b1; data = 16'h4321;
    step();
    load = 1'b0;
    while (t < 64) begin
      if (o_bus !== 4'h0) begin $display("FAIL bnd_o_hold t=%0d got %h want 0", t, o_bus); errs++; end
      vecs++;
      if (ready !== 1'b0) begin $display("FAIL bnd_ready_lo t=%0d got %b want 0", t, ready); errs++; end
      vecs++;
      if (an !== exp_an(t, ZERO_MASK)) begin
        $display("FAIL bnd_an_hold t=%0d got %b want %b", t, an, exp_an(t, ZERO_MASK)); errs++;
      end
      vecs++;
      step();
    end
    while (t < 96) begin
      if (o_bus !== exp_nib(t, 16'h4321)) begin
        $display("FAIL bnd_o_new t=%0d got %h want %h", t, o_bus, exp_nib(t, 16'h4321)); errs++;
      end
      vecs++;
      if (ready !== 1'b1) begin $display("FAIL bnd_ready_hi t=%0d got %b want 1", t, ready); errs++; end
      vecs++;
      if (an !== exp_an(t, 4'hF)) begin
        $display("FAIL bnd_an_new t=%0d got %b want %b", t, an, exp_an(t, 4'hF)); errs++;
      end
      vecs++;
      step();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    while (t < 3) step();
    load = 1'b1; data = 16'h5555;
    step();
    load = 1'b0;
    while (t < 33) step();
    load = 1'b1; data = 16'h0606;
    step();
    load = 1'b0;
    while (t < 42) step();
    if (an !== 4'b1101) begin $display("FAIL mid_pre_an got %b want 1101", an); errs++; end
    vecs++;
    if (ready !== 1'b0) begin $display("FAIL mid_pre_ready got %b want 0", ready); errs++; end
    vecs++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    t = 0;
    if (an !== 4'hF) begin $display("FAIL mid_rst_an got %b want 1111", an); errs++; end
    vecs++;
    if (o_bus !== 4'h0) begin $display("FAIL mid_rst_o got %h want 0", o_bus); errs++; end
    vecs++;
    if (ready !== 1'b1) begin $display("FAIL mid_rst_ready got %b want 1", ready); errs++; end
    vecs++;
    while (t < 64) begin
      if (o_bus !== 4'h0) begin $display("FAIL mid_o t=%0d got %h want 0", t, o_bus); errs++; end
      vecs++;
      if (an !== exp_an(t, ZERO_MASK)) begin
        $display("FAIL mid_an t=%0d got %b want %b", t, an, exp_an(t, ZERO_MASK)); errs++;
      end
      vecs++;
      if (ready !== 1'b1) begin $display("FAIL mid_ready t=%0d got %b want 1", t, ready); errs++; end
      vecs++;
      step();
    end
  endtask

  task automatic test_lzb();
    do_reset();
    load = 1'b1; data = 16'h0070;
    step();
    load = 1'b0;
    while (t < 32) step();
    while (t < 64) begin
      if (t == 40) begin
        load = 1'b1; data = 16'h0000;
        step();
        load = 1'b0;
      end
      if (an !== exp_an(t, M0070)) begin
        $display("FAIL lzb70_an t=%0d got %b want %b", t, an, exp_an(t, M0070)); errs++;
      end
      vecs++;
      if (o_bus !== exp_nib(t, 16'h0070)) begin
        $display("FAIL lzb70_o t=%0d got %h want %h", t, o_bus, exp_nib(t, 16'h0070)); errs++;
      end
      vecs++;
      step();
    end
    while (t < 96) begin
      if (an !== exp_an(t, ZERO_MASK)) begin
        $display("FAIL lzb00_an t=%0d got %b want %b", t, an, exp_an(t, ZERO_MASK)); errs++;
      end
      vecs++;
      if (o_bus !== 4'h0) begin $display("FAIL lzb00_o t=%0d got %h want 0", t, o_bus); errs++; end
      vecs++;
      if (frame_tick !== exp_ft(t)) begin
        $display("FAIL lzb00_ft t=%0d got %b want %b", t, frame_tick, exp_ft(t)); errs++;
      end
      vecs++;
      step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    t    = 0;
    vecs = 0;
    errs = 0;
    test_reset();
    test_scan();
    test_load();
    test_rejected_load();
    test_boundary_load();
    test_mid_reset();
    test_lzb();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
